// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the fetch PC unit
package fetch_pkg;

  localparam int          XLEN                = 32;
  localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam int          DEFAULT_BTB_ENTRIES = 16;

  // Tag field is sized for the smallest legal BTB; narrower tags sit zero-extended.
  typedef struct packed {
    logic            valid;
    logic [XLEN-3:0] tag;
    logic [XLEN-1:0] target;
  } btb_entry_t;

  typedef enum logic [1:0] {
    PC_REDIRECT,
    PC_HOLD,
    PC_PRED,
    PC_SEQ
  } pc_sel_e;

  function automatic logic [XLEN-3:0] btb_tag(input logic [XLEN-1:0] pc, input int index_bits);
    return pc[XLEN-1:2] >> index_bits;
  endfunction

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_btb.sv
// rtl/fetch_pc_unit_btb.sv - direct-mapped branch target buffer
// Combinational lookup on the fetch PC, synchronous write from execute, no write-to-read bypass.
module btb
  import fetch_pkg::*;
#(
  parameter int ENTRIES = DEFAULT_BTB_ENTRIES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit,
  output logic [XLEN-1:0] target,
  input  logic            write_en,
  input  logic [XLEN-1:0] write_pc,
  input  logic [XLEN-1:0] write_target
);

  localparam int INDEX_BITS = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [XLEN-3:0]    tags    [ENTRIES];
  logic [XLEN-1:0]    targets [ENTRIES];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  btb_entry_t            rd_entry;

  assign rd_idx = lookup_pc[INDEX_BITS+1:2];
  assign wr_idx = write_pc[INDEX_BITS+1:2];

  assign rd_entry = '{valid: valid[rd_idx], tag: tags[rd_idx], target: targets[rd_idx]};
  assign hit      = rd_entry.valid && (rd_entry.tag == btb_tag(lookup_pc, INDEX_BITS));
  assign target   = rd_entry.target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (write_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tags and targets are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      tags[wr_idx]    <= btb_tag(write_pc, INDEX_BITS);
      targets[wr_idx] <= write_target;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-stage PC register, next-PC priority mux and redirect counter
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          BTB_ENTRIES = DEFAULT_BTB_ENTRIES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        predict_taken_i,
  input  logic        execute_is_branch_i,
  input  logic        execute_branch_taken_i,
  input  logic [31:0] execute_pc_i,
  input  logic [31:0] execute_target_i,
  input  logic        execute_mispredict_i,
  input  logic [31:0] execute_redirect_pc_i,
  output logic [31:0] fetch_pc_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  output logic [31:0] redirect_count_o
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        btb_hit;
  logic [31:0] btb_target;
  pc_sel_e     pc_sel;

  btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc    (pc),
    .hit          (btb_hit),
    .target       (btb_target),
    .write_en     (execute_is_branch_i && execute_branch_taken_i),
    .write_pc     (execute_pc_i),
    .write_target (execute_target_i)
  );

  assign pc_plus4      = pc + 32'd4;
  assign pred_taken_o  = predict_taken_i && btb_hit;
  assign pred_target_o = pred_taken_o ? btb_target : pc_plus4;
  assign fetch_pc_o    = pc;

  // A redirect wins over a stall: the stalled instruction is on the wrong path anyway.
  always_comb begin
    pc_sel = PC_SEQ;
    if (execute_mispredict_i) begin
      pc_sel = PC_REDIRECT;
    end else if (stall_i) begin
      pc_sel = PC_HOLD;
    end else if (pred_taken_o) begin
      pc_sel = PC_PRED;
    end
  end

  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      PC_REDIRECT: next_pc = align_pc(execute_redirect_pc_i);
      PC_HOLD:     next_pc = pc;
      PC_PRED:     next_pc = align_pc(btb_target);
      PC_SEQ:      next_pc = pc_plus4;
      default:     next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= align_pc(RESET_PC);
    end else begin
      pc <= next_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_count_o <= '0;
    end else if (execute_mispredict_i && (redirect_count_o != 32'hFFFF_FFFF)) begin
      redirect_count_o <= redirect_count_o + 32'd1;
    end
  end

endmodule
